eeprom_burst_seq: RTL and testbench

Burst sequencer that sits directly upstream of `iic_ctrl`. On a write or read start pulse it issues one single-byte I2C transaction per address over a programmable burst, using an incrementing address and incrementing write data. It handshakes on `iic_done`, enforces the EEPROM internal write-cycle time, and presents each read byte as a one-cycle strobe suitable for driving the display FIFO `wrreq`/`data`. It replaces fixed-interval transaction timers with a done-driven handshake and adds a watchdog.

---
 rtl/eeprom_burst_seq.sv | 172 +++++++++++++++++
 tb/tb_eeprom_burst_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_burst_seq.sv
// Burst sequencer in front of iic_ctrl: one single-byte I2C transaction per address,
// done-driven handshake, EEPROM write-cycle wait and a per-byte watchdog.
module eeprom_burst_seq #(
  parameter int unsigned TWR_CNT     = 250_000,
  parameter int unsigned TIMEOUT_CNT = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_start,
  input  logic        rd_start,
  input  logic [15:0] base_addr,
  input  logic [7:0]  wr_data0,
  input  logic [4:0]  burst_len,
  output logic        iic_wr_en,
  output logic        iic_rd_en,
  output logic [15:0] iic_addr,
  output logic [7:0]  iic_data,
  input  logic        iic_done,
  input  logic [7:0]  iic_rd_data,
  output logic        rd_valid,
  output logic [7:0]  rd_byte,
  output logic        busy,
  output logic        burst_done,
  output logic        timeout_err
);

  localparam int unsigned CMAX = (TIMEOUT_CNT > TWR_CNT) ? TIMEOUT_CNT : TWR_CNT;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CNT - 1);
  localparam logic [CW-1:0] TWR_LAST = CW'(TWR_CNT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WAIT_TWR, NEXT} state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;   // 1 = write burst
  logic [4:0]    len_q, len_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rd_byte_q, rd_byte_d;
  logic          wr_en_q, wr_en_d;
  logic          rd_en_q, rd_en_d;
  logic          rd_valid_q, rd_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;

  logic len_ok;
  logic last_byte;

  assign len_ok    = (burst_len != '0) && (burst_len <= 5'd16);
  assign last_byte = ({1'b0, idx_q} == (len_q - 5'd1));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_byte_d  = rd_byte_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    tmo_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if ((wr_start || rd_start) && len_ok) begin
          mode_d  = wr_start;
          addr_d  = base_addr;
          data_d  = wr_data0;
          len_d   = burst_len;
          idx_d   = '0;
          wr_en_d = wr_start;
          rd_en_d = !wr_start;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Done in the final count cycle takes priority over the watchdog.
        if (iic_done) begin
          cnt_d = '0;
          if (mode_q) begin
            state_d = WAIT_TWR;
          end else begin
            rd_byte_d  = iic_rd_data;
            rd_valid_d = 1'b1;
            state_d    = NEXT;
          end
        end else if (cnt_q == TO_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_TWR: begin
        if (cnt_q == TWR_LAST) state_d = NEXT;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      NEXT: begin
        if (last_byte) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + 16'd1;
          data_d  = data_q + 8'd1;
          idx_d   = idx_q + 4'd1;
          wr_en_d = mode_q;
          rd_en_d = !mode_q;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_byte_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_byte_q  <= rd_byte_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  assign iic_wr_en   = wr_en_q;
  assign iic_rd_en   = rd_en_q;
  assign iic_addr    = addr_q;
  assign iic_data    = data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_byte     = rd_byte_q;
  assign busy        = busy_q;
  assign burst_done  = done_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_eeprom_burst_seq.sv
// Directed bench for eeprom_burst_seq with a delay-programmable iic_ctrl responder.
module tb_eeprom_burst_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_start, rd_start;
  logic [15:0] base_addr;
  logic [7:0]  wr_data0;
  logic [4:0]  burst_len;
  logic        iic_wr_en, iic_rd_en;
  logic [15:0] iic_addr;
  logic [7:0]  iic_data;
  logic        iic_done;
  logic [7:0]  iic_rd_data;
  logic        rd_valid;
  logic [7:0]  rd_byte;
  logic        busy, burst_done, timeout_err;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  bit resp_on = 1'b1;
  int resp_delay = 20;
  int cnt_rdv = 0, cnt_bd = 0, cnt_to = 0;

  localparam int SIG_REQ = 0, SIG_RDV = 1, SIG_BD = 2, SIG_TMO = 3;

  eeprom_burst_seq #(.TWR_CNT(100), .TIMEOUT_CNT(64)) dut (
    .clk(clk), .rst(rst), .wr_start(wr_start), .rd_start(rd_start),
    .base_addr(base_addr), .wr_data0(wr_data0), .burst_len(burst_len),
    .iic_wr_en(iic_wr_en), .iic_rd_en(iic_rd_en), .iic_addr(iic_addr),
    .iic_data(iic_data), .iic_done(iic_done), .iic_rd_data(iic_rd_data),
    .rd_valid(rd_valid), .rd_byte(rd_byte), .busy(busy),
    .burst_done(burst_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_valid)    cnt_rdv <= cnt_rdv + 1;
    if (burst_done)  cnt_bd  <= cnt_bd + 1;
    if (timeout_err) cnt_to  <= cnt_to + 1;
  end

  // iic_ctrl model: done pulse resp_delay cycles after a request, data = addr[7:0]
  initial begin : responder
    logic [15:0] a;
    iic_done = 1'b0;
    iic_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (resp_on && (iic_wr_en || iic_rd_en)) begin
        a = iic_addr;
        repeat (resp_delay) @(negedge clk);
        iic_done = 1'b1;
        iic_rd_data = a[7:0];
        @(negedge clk);
        iic_done = 1'b0;
      end
    end
  end

  initial begin : global_guard
    #400000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench did not terminate");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      SIG_REQ: return iic_wr_en | iic_rd_en;
      SIG_RDV: return rd_valid;
      SIG_BD:  return burst_done;
      default: return timeout_err;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sig_sel(sel)) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Called at a negedge: start visible in cycle t0, returns at the negedge of t0+1.
  task automatic do_start(input logic w, input logic r, input logic [15:0] a,
                          input logic [7:0] d, input logic [4:0] l, output int t0);
    t0 = cyc;
    wr_start = w; rd_start = r; base_addr = a; wr_data0 = d; burst_len = l;
    @(negedge clk);
    wr_start = 1'b0; rd_start = 1'b0;
  endtask

  initial begin : stimulus
    int t0, t, tr, tv, snap_rdv, snap_bd, snap_to;
    rst = 1'b1; wr_start = 1'b0; rd_start = 1'b0;
    base_addr = '0; wr_data0 = '0; burst_len = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {26'd0, busy, iic_wr_en, iic_rd_en, rd_valid, burst_done, timeout_err}, 32'd0);
    chk("reset_data", {iic_addr, iic_data, rd_byte}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // write burst: 5A/5B/5C, 107/108/109, 122-cycle spacing
    resp_delay = 20;
    do_start(1'b1, 1'b0, 16'h005A, 8'd107, 5'd3, t0);
    chk("wr_cyc1", {busy, iic_wr_en, iic_rd_en}, 3'b110);
    chk("wr_addr0", iic_addr, 16'h005A);
    chk("wr_data0", iic_data, 8'd107);
    tr = cyc;
    for (int i = 1; i < 3; i++) begin
      wait_for(SIG_REQ, 300, t);
      chk("wr_spacing", t - tr, 122);
      chk("wr_strobe", {iic_wr_en, iic_rd_en}, 2'b10);
      chk("wr_addr", iic_addr, 16'h005A + i);
      chk("wr_data", iic_data, 107 + i);
      tr = t;
    end
    wait_for(SIG_BD, 300, t);
    chk("wr_done_cyc", t - tr, 122);
    chk("wr_done_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("wr_no_rdv", cnt_rdv, 0);
    chk("wr_one_done", cnt_bd, 1);

    // read burst: 10 bytes, rd_byte = 5A..63 at done+1
    do_start(1'b0, 1'b1, 16'h005A, 8'h00, 5'd10, t0);
    tr = cyc;
    tv = tr;
    chk("rd_cyc1", {busy, iic_wr_en, iic_rd_en}, 3'b101);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        wait_for(SIG_REQ, 100, tr);
        chk("rd_req_gap", tr - tv, 1);
        chk("rd_strobe", {iic_wr_en, iic_rd_en}, 2'b01);
      end
      chk("rd_addr", iic_addr, 16'h005A + i);
      wait_for(SIG_RDV, 100, tv);
      chk("rd_valid_cyc", tv - tr, 21);
      chk("rd_byte", rd_byte, 8'h5A + i);
    end
    wait_for(SIG_BD, 20, t);
    chk("rd_done_cyc", t - tv, 1);
    chk("rd_done_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("rd_byte_hold", rd_byte, 8'h63);
    chk("rd_valid_count", cnt_rdv, 10);

    // address/data wrap
    do_start(1'b1, 1'b0, 16'hFFFF, 8'hFF, 5'd2, t0);
    chk("wrap_addr0", {iic_addr, iic_data}, 24'hFFFFFF);
    wait_for(SIG_REQ, 300, t);
    chk("wrap_addr1", {iic_addr, iic_data}, 24'h000000);
    wait_for(SIG_BD, 300, t);
    chk("wrap_done", t == -1, 1'b0);
    repeat (2) @(negedge clk);

    // both starts -> write; rd_start while busy ignored
    snap_rdv = cnt_rdv;
    do_start(1'b1, 1'b1, 16'h0100, 8'h11, 5'd1, t0);
    chk("arb_write", {iic_wr_en, iic_rd_en}, 2'b10);
    chk("arb_addr", iic_addr, 16'h0100);
    tr = cyc;
    @(negedge clk);
    rd_start = 1'b1; base_addr = 16'h0200; burst_len = 5'd5;
    @(negedge clk);
    rd_start = 1'b0;
    wait_for(SIG_BD, 300, t);
    chk("arb_done_cyc", t - tr, 122);
    wait_for(SIG_REQ, 30, t);
    chk("busy_start_ignored", t, -1);
    chk("arb_no_rdv", cnt_rdv, snap_rdv);

    // illegal lengths 0 and 17
    do_start(1'b1, 1'b0, 16'h0300, 8'h00, 5'd0, t0);
    chk("len0_idle", {busy, iic_wr_en, iic_rd_en}, 3'b000);
    wait_for(SIG_REQ, 20, t);
    chk("len0_noreq", t, -1);
    do_start(1'b0, 1'b1, 16'h0300, 8'h00, 5'd17, t0);
    chk("len17_idle", {busy, iic_wr_en, iic_rd_en}, 3'b000);
    wait_for(SIG_REQ, 20, t);
    chk("len17_noreq", t, -1);

    // watchdog: silent model, timeout_err in cycle 66
    snap_bd = cnt_bd;
    resp_on = 1'b0;
    do_start(1'b0, 1'b1, 16'h0400, 8'h00, 5'd1, t0);
    wait_for(SIG_TMO, 200, t);
    chk("tmo_cyc", t - t0, 66);
    chk("tmo_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("tmo_no_done", cnt_bd, snap_bd);
    chk("tmo_count", cnt_to, 1);

    // responsive read after timeout completes normally
    resp_on = 1'b1;
    resp_delay = 20;
    do_start(1'b0, 1'b1, 16'h0500, 8'h00, 5'd2, t0);
    wait_for(SIG_BD, 200, t);
    chk("post_tmo_done_cyc", t - t0, 45);
    chk("post_tmo_byte", rd_byte, 8'h01);

    // done exactly at watchdog count 63 is accepted
    resp_delay = 64;
    do_start(1'b0, 1'b1, 16'h0077, 8'h00, 5'd1, t0);
    wait_for(SIG_RDV, 200, t);
    chk("edge_rdv_cyc", t - t0, 66);
    chk("edge_rd_byte", rd_byte, 8'h77);
    wait_for(SIG_BD, 20, t);
    chk("edge_done_cyc", t - t0, 67);
    repeat (2) @(negedge clk);
    chk("edge_no_tmo", cnt_to, 1);

    // asynchronous reset during WAIT_TWR of byte 2
    resp_delay = 20;
    do_start(1'b1, 1'b0, 16'h0020, 8'h40, 5'd3, t0);
    wait_for(SIG_REQ, 300, t);
    chk("rst_byte2_addr", iic_addr, 16'h0021);
    repeat (50) @(negedge clk);
    chk("rst_busy_before", busy, 1'b1);
    snap_bd = cnt_bd;
    snap_to = cnt_to;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ctrl", {26'd0, busy, iic_wr_en, iic_rd_en, rd_valid, burst_done, timeout_err}, 32'd0);
    chk("rst_async_data", {iic_addr, iic_data, rd_byte}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_pulses", {cnt_bd - snap_bd, cnt_to - snap_to}, 32'd0);
    do_start(1'b1, 1'b0, 16'h0010, 8'h00, 5'd1, t0);
    chk("post_rst_strobe", {busy, iic_wr_en}, 2'b11);
    chk("post_rst_addr", iic_addr, 16'h0010);
    wait_for(SIG_BD, 300, t);
    chk("post_rst_done", t == -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
